multiplicador_8bits_seq: RTL and testbench
==========================================

# multiplicador_8bits_seq

Sequential 8×8 unsigned shift-and-add multiplier with a 16-bit product. It reuses a single `somador_8bits` instance and feeds it one partial product per clock. The block owns the control FSM, the operand and accumulator registers, and a start/busy/done handshake. It is the ALU's multiply path and shares the existing adder datapath rather than adding an array multiplier.

## Interface
- Parameters: none. Width is fixed at 8 by `somador_8bits`.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request. Sampled only in state OCIOSO.
- `A`  in  8  multiplicand. Captured on the accepting edge.
- `B`  in  8  multiplier. Captured on the accepting edge.
- `P`  out  16  product register. Holds the last result until the next result is written.
- `busy`  out  1  high whenever state ≠ OCIOSO.
- `done`  out  1  one-cycle pulse; `P` is valid in that cycle.

## Operation
- Internal registers:
  - `M[7:0]`: multiplicand.
  - `Q[7:0]`: multiplier, which becomes the product low byte.
  - `ACC[7:0]`: product high byte.
  - `cnt[2:0]`: iteration counter.
  - `estado`.
- FSM states: OCIOSO, CALC, FIM.
- OCIOSO:
  - If `start`=1 at an edge: load `M=A`, `Q=B`, `ACC=0`, `cnt=0`; go to CALC.
  - Otherwise stay in OCIOSO.
- CALC, one iteration per edge:
  - The adder computes `{C_out,S} = ACC + (Q[0] ? M : 8'h00)`.
  - Register update: `{ACC,Q} <= {C_out,S,Q[7:1]}`, a 17-bit right shift, so no carry is lost.
  - `cnt` increments every iteration.
  - When `cnt`==7 at the edge, go to FIM and load `P <= {C_out,S,Q[7:1]}`.
- FIM: `done`=1 for exactly one cycle, then OCIOSO on the next edge.
- `start` in CALC or FIM is ignored. Operands on `A`/`B` are not re-sampled.
- Arithmetic: unsigned only. The product always fits in 16 bits; `0xFF×0xFF` = `0xFE01`.
- Reset, asserted in any state including mid-CALC, at the next edge:
  - `estado`=OCIOSO.
  - `P`=0, `done`=0, `busy`=0.
  - `M`, `Q`, `ACC`, `cnt` cleared.
  - The aborted operation never raises `done`.
- `rst` and `start` high on the same edge: reset wins and the request is dropped.

## Timing
- Edge e0 samples `start`=1 in OCIOSO. CALC iterations run on edges e1..e8.
- `done`=1 and new `P` are visible in the cycle after e8.
- Edge e9 returns to OCIOSO. The earliest next accepted `start` is at e10, giving a throughput of one product per 10 cycles.
- `busy` rises in the cycle after e0 and falls in the cycle after e9.
- The adder is combinational between registers. The critical path is the 8-bit ripple plus the 2:1 operand mux.

## Configuration
- Macro `MULT_ATALHO_ZERO_EN`.
- Defined:
  - If `A`==0 or `B`==0 on the accepting edge, go OCIOSO→FIM directly and load `P`=0.
  - `done` is visible in the cycle after e0.
  - `busy` is high for that one cycle only.
- Undefined: every operation takes the full 8 iterations, including zero operands.

## Structure
- Shared package `mult_pkg`:
  - Constant `LARGURA`=8.
  - Constant `N_ITER`=8.
  - FSM state typedef/encoding (OCIOSO=2'd0, CALC=2'd1, FIM=2'd2).
- Sub-module: one instance of the existing `somador_8bits`, ports A=`ACC`, B=gated `M`, S, C_out.
- No other sub-modules. The FSM, registers and shift logic are local.

## Test plan
- Reset held 2 cycles, `start`=0 → `P`=0x0000, `busy`=0, `done`=0 throughout.
- `A`=13, `B`=11, `start` pulse at e0 → `busy` high from the next cycle; `done` pulse in the cycle after e8 with `P`=143 (0x008F); `busy` low after e9.
- `A`=0xFF, `B`=0xFF → `P`=0xFE01 (checks the carry into the shift). Follow with `A`=0x80, `B`=0x02 → `P`=0x0100.
- `start` held high for 12 cycles, operands changed to 3/4 at e3 → the first result uses the e0 operands. A second operation is accepted at e10 with `A`=3, `B`=4, giving `P`=12.
- `rst` asserted in the 4th CALC cycle → next cycle `busy`=0, `P`=0; no `done` pulse within the following 10 cycles.
- `A`=0, `B`=200 → with `MULT_ATALHO_ZERO_EN`: `done` in the cycle after e0, `P`=0. Without it: `done` in the cycle after e8, `P`=0.

Source files
------------

// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mult_pkg
// Description : Shared widths and FSM encoding for the sequential multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
package mult_pkg;

    localparam int LARGURA = 8;
    localparam int N_ITER  = 8;
    localparam int CNT_W   = $clog2(N_ITER);

    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        CALC   = 2'd1,
        FIM    = 2'd2
    } estado_t;

endpackage
`default_nettype wire

// File: rtl/somador_8bits.sv
`default_nettype none
// ============================================================================
// Module      : somador_8bits
// Description : Combinational 8-bit unsigned adder with carry out.
// Revision    : 1.0 - initial release
// ============================================================================
module somador_8bits (
    input  logic [7:0] A,
    input  logic [7:0] B,
    output logic [7:0] S,
    output logic       C_out
);

    assign {C_out, S} = {1'b0, A} + {1'b0, B};

endmodule
`default_nettype wire

// File: rtl/multiplicador_8bits_seq.sv
`default_nettype none
// ============================================================================
// Module      : multiplicador_8bits_seq
// Description : 8x8 unsigned shift-and-add multiplier, one partial product per
//               clock through a shared somador_8bits. Optional macro
//               MULT_ATALHO_ZERO_EN skips iterations for zero operands.
// Revision    : 1.0 - initial release
// ============================================================================
module multiplicador_8bits_seq
    import mult_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [LARGURA-1:0]     A,
    input  logic [LARGURA-1:0]     B,
    output logic [2*LARGURA-1:0]   P,
    output logic                   busy,
    output logic                   done
);

    localparam logic [CNT_W-1:0] c_cnt_ult = CNT_W'(N_ITER - 1);

    estado_t              r_estado;
    estado_t              w_prox;
    logic [LARGURA-1:0]   r_m;
    logic [LARGURA-1:0]   r_q;
    logic [LARGURA-1:0]   r_acc;
    logic [CNT_W-1:0]     r_cnt;
    logic [LARGURA-1:0]   w_oper;
    logic [LARGURA-1:0]   w_s;
    logic                 w_cout;
    logic [2*LARGURA-1:0] w_desloc;
    logic                 w_ultima;
    logic                 w_zero;

    assign w_oper = r_q[0] ? r_m : '0;

    somador_8bits u_somador (
        .A     (r_acc),
        .B     (w_oper),
        .S     (w_s),
        .C_out (w_cout)
    );

    // Carry enters the top of the shift so the 17-bit {C,S,Q} loses only Q[0].
    assign w_desloc = {w_cout, w_s, r_q[LARGURA-1:1]};
    assign w_ultima = (r_cnt == c_cnt_ult);

`ifdef MULT_ATALHO_ZERO_EN
    assign w_zero = (A == '0) || (B == '0);
`else
    assign w_zero = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_estado <= OCIOSO;
        end else begin
            r_estado <= w_prox;
        end
    end

    always_comb begin
        w_prox = r_estado;
        busy   = 1'b1;
        done   = 1'b0;
        case (r_estado)
            OCIOSO: begin
                busy = 1'b0;
                if (start) begin
                    w_prox = w_zero ? FIM : CALC;
                end
            end
            CALC: begin
                if (w_ultima) begin
                    w_prox = FIM;
                end
            end
            FIM: begin
                done   = 1'b1;
                w_prox = OCIOSO;
            end
            default: begin
                w_prox = OCIOSO;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_m   <= '0;
            r_q   <= '0;
            r_acc <= '0;
            r_cnt <= '0;
            P     <= '0;
        end else begin
            case (r_estado)
                OCIOSO: begin
                    if (start) begin
                        r_m   <= A;
                        r_q   <= B;
                        r_acc <= '0;
                        r_cnt <= '0;
                        if (w_zero) begin
                            P <= '0;
                        end
                    end
                end
                CALC: begin
                    {r_acc, r_q} <= w_desloc;
                    r_cnt        <= r_cnt + CNT_W'(1);
                    if (w_ultima) begin
                        P <= w_desloc;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_multiplicador_8bits_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_multiplicador_8bits_seq
// Description : Scoreboard bench for the sequential multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multiplicador_8bits_seq;

    typedef struct {
        logic [15:0] p;
        int          edge_no;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  A;
    logic [7:0]  B;
    logic [15:0] P;
    logic        busy;
    logic        done;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   edge_cnt = 0;
    int   n_done   = 0;
    logic [15:0] last_p = 16'h0;
    exp_t sb[$];

    multiplicador_8bits_seq dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .P     (P),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h required=0x%0h (edge %0d)", name, act, req, edge_cnt);
        end
    endtask

    // Reference: plain unsigned product; latency counted from the accepting edge.
    function automatic int latencia(input logic [7:0] a, input logic [7:0] b);
`ifdef MULT_ATALHO_ZERO_EN
        if (a == 8'd0 || b == 8'd0) return 0;
`endif
        return 8;
    endfunction

    function automatic logic [15:0] produto(input logic [7:0] a, input logic [7:0] b);
        return 16'(int'(a) * int'(b));
    endfunction

    always @(negedge clk) begin
        if (done) begin
            n_done++;
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("product", {16'h0, P}, {16'h0, e.p});
                chk("done_edge", edge_cnt, e.edge_no);
                last_p = e.p;
            end
        end
    end

    task automatic esperar_vazio(input string name);
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            chk({name, "_timeout"}, sb.size(), 0);
            sb.delete();
        end
    endtask

    task automatic operar(input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        @(negedge clk);
        chk("p_hold", {16'h0, P}, {16'h0, last_p});
        A = a; B = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        A = $urandom; B = $urandom;
        e.p = produto(a, b);
        e.edge_no = edge_cnt + latencia(a, b);
        sb.push_back(e);
        chk("busy_rise", {31'h0, busy}, 32'd1);
        esperar_vazio("op");
        @(negedge clk);
        chk("busy_fall", {31'h0, busy}, 32'd0);
    endtask

    initial begin
        exp_t e;
        int   e0;
        int   base_done;
        logic [7:0] a0, b0;

        rst = 1'b1; start = 1'b0; A = 8'h0; B = 8'h0;
        repeat (2) begin
            @(negedge clk);
            chk("rst_P", {16'h0, P}, 32'd0);
            chk("rst_busy", {31'h0, busy}, 32'd0);
            chk("rst_done", {31'h0, done}, 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        chk("idle_busy", {31'h0, busy}, 32'd0);

        operar(8'd13, 8'd11);
        operar(8'hFF, 8'hFF);
        operar(8'h80, 8'h02);
        operar(8'd0, 8'd200);
        operar(8'd1, 8'd0);

        // start held 12 cycles, operands changed after e3: second accept at e10
        a0 = 8'($urandom_range(1, 255));
        b0 = 8'($urandom_range(1, 255));
        @(negedge clk);
        A = a0; B = b0; start = 1'b1;
        @(posedge clk); #1;
        e0 = edge_cnt;
        e.p = produto(a0, b0);   e.edge_no = e0 + 8;  sb.push_back(e);
        e.p = produto(8'd3, 8'd4); e.edge_no = e0 + 18; sb.push_back(e);
        repeat (3) @(posedge clk);
        #1; A = 8'd3; B = 8'd4;
        repeat (8) @(posedge clk);
        #1; start = 1'b0;
        esperar_vazio("held_start");
        @(negedge clk);

        // reset in the 4th CALC cycle aborts without done
        @(negedge clk);
        A = 8'd77; B = 8'd99; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_busy", {31'h0, busy}, 32'd0);
        chk("abort_P", {16'h0, P}, 32'd0);
        last_p = 16'h0;
        base_done = n_done;
        repeat (10) @(negedge clk);
        chk("abort_no_done", n_done - base_done, 0);

        // rst and start on the same edge: request dropped
        @(negedge clk);
        rst = 1'b1; start = 1'b1; A = 8'd5; B = 8'd6;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        chk("rst_wins_busy", {31'h0, busy}, 32'd0);
        base_done = n_done;
        repeat (10) @(negedge clk);
        chk("rst_wins_no_done", n_done - base_done, 0);

        for (int i = 0; i < 20; i++) begin
            logic [7:0] ra, rb;
            ra = 8'($urandom);
            rb = 8'($urandom);
            if ($urandom_range(0, 5) == 0) ra = 8'd0;
            if ($urandom_range(0, 5) == 0) rb = 8'd0;
            operar(ra, rb);
        end

        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
